// File: rtl/fetch_unit.sv
// fetch_unit: program counter, next-PC selection from a writable target table, and start/halt sequencing
module fetch_unit #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   StartAddr,
    input  logic              Halt,
    input  logic              Stall,
    input  logic              jump_en,
    input  logic              branch_en,
    input  logic [LUT_AW-1:0] TargetIdx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_addr,
    input  logic [PC_W-1:0]   lut_data,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              Running,
    output logic              Done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] lut_q [2**LUT_AW];
    logic [PC_W-1:0] tgt;

    always_comb begin
        tgt     = lut_q[TargetIdx];
        state_d = state_q;
        pc_d    = pc_q;
        if (state_q == RUN) begin
            if (Halt)
                state_d = DONE;
            else if (!Stall)
                pc_d = jump_en ? tgt : branch_en ? pc_q + tgt : pc_q + 1'b1;
        end else if (Start) begin
            state_d = RUN;
            pc_d    = StartAddr;
        end
        running_d = state_d == RUN;
        done_d    = state_d == DONE;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // write lands at the edge, so a same-cycle read above still sees the old entry
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 2**LUT_AW; i++) lut_q[i] <= '0;
        end else if (lut_we) begin
            lut_q[lut_addr] <= lut_data;
        end
    end

    assign ProgCtr = pc_q;
    assign Running = running_q;
    assign Done    = done_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a cycle-level reference model
module tb_fetch_unit;
    localparam int PW = 10;
    localparam int AW = 5;

    logic          Clk = 0, Reset = 0, Start = 0, Halt = 0, Stall = 0;
    logic          jump_en = 0, branch_en = 0, lut_we = 0;
    logic [PW-1:0] StartAddr = '0, lut_data = '0;
    logic [AW-1:0] TargetIdx = '0, lut_addr = '0;
    logic [PW-1:0] ProgCtr;
    logic          Running, Done;

    int vectors = 0;
    int errors  = 0;
    int m_pc, m_st;
    int m_lut [2**AW];

    fetch_unit #(.PC_W(PW), .LUT_AW(AW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Halt(Halt), .Stall(Stall), .jump_en(jump_en), .branch_en(branch_en),
        .TargetIdx(TargetIdx), .lut_we(lut_we), .lut_addr(lut_addr),
        .lut_data(lut_data), .ProgCtr(ProgCtr), .Running(Running), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_st = 0;
        foreach (m_lut[i]) m_lut[i] = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"}, 32'(ProgCtr), m_pc);
        chk({tag, ".running"}, 32'(Running), (m_st == 1) ? 1 : 0);
        chk({tag, ".done"}, 32'(Done), (m_st == 2) ? 1 : 0);
    endtask

    task automatic quiet();
        Start = 0; Halt = 0; Stall = 0; jump_en = 0; branch_en = 0; lut_we = 0;
    endtask

    // model state: 0 idle, 1 run, 2 done; PC arithmetic is plain modulo 2^PW
    task automatic cycle(input string tag);
        int npc, nst, t;
        t   = m_lut[TargetIdx];
        npc = m_pc;
        nst = m_st;
        if (m_st != 1 && Start) begin
            npc = StartAddr; nst = 1;
        end else if (m_st == 1) begin
            if (Halt) nst = 2;
            else if (Stall) npc = m_pc;
            else if (jump_en) npc = t;
            else if (branch_en) npc = (m_pc + t) % (1 << PW);
            else npc = (m_pc + 1) % (1 << PW);
        end
        @(posedge Clk);
        #1;
        if (!Reset) model_reset();
        else begin
            if (lut_we) m_lut[lut_addr] = lut_data;
            m_pc = npc;
            m_st = nst;
        end
        check_model(tag);
    endtask

    task automatic lut_write(input int a, input int d);
        lut_we = 1; lut_addr = AW'(a); lut_data = PW'(d);
        cycle("lutw");
        lut_we = 0;
    endtask

    initial begin
        model_reset();
        #3;
        check_model("reset");
        #9 Reset = 1;

        lut_write(3, 'h200);
        lut_write(4, 'h3FE);
        lut_write(5, 'h001);
        lut_write(6, 'h020);
        lut_write(7, 'h155);

        Start = 1; StartAddr = 'h010;
        cycle("start");
        chk("start_pc", 32'(ProgCtr), 'h010);
        chk("start_run", 32'(Running), 1);
        Start = 0;
        cycle("seq1");
        chk("seq1_pc", 32'(ProgCtr), 'h011);
        cycle("seq2");
        chk("seq2_pc", 32'(ProgCtr), 'h012);

        jump_en = 1; TargetIdx = 3;
        cycle("jump");
        chk("jump_pc", 32'(ProgCtr), 'h200);
        branch_en = 1;
        cycle("jump_branch");
        chk("jump_branch_pc", 32'(ProgCtr), 'h200);
        branch_en = 0; TargetIdx = 5;
        cycle("to1");
        jump_en = 0; branch_en = 1; TargetIdx = 4;
        cycle("branch");
        chk("branch_pc", 32'(ProgCtr), 'h3FF);
        branch_en = 0;
        cycle("wrap");
        chk("wrap_pc", 32'(ProgCtr), 'h000);

        jump_en = 1; TargetIdx = 6;
        cycle("to20");
        jump_en = 0; Stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall_pc", 32'(ProgCtr), 'h020);
        end
        Stall = 0;
        cycle("unstall");
        chk("unstall_pc", 32'(ProgCtr), 'h021);
        jump_en = 1;
        cycle("back20");
        jump_en = 0; Halt = 1; Stall = 1;
        cycle("halt");
        chk("halt_done", 32'(Done), 1);
        chk("halt_pc", 32'(ProgCtr), 'h020);
        quiet();
        branch_en = 1;
        cycle("done_hold");
        branch_en = 0; jump_en = 1; Start = 1; StartAddr = 'h040;
        cycle("restart");
        chk("restart_pc", 32'(ProgCtr), 'h040);
        chk("restart_done", 32'(Done), 0);
        quiet();

        // same-entry write and read: old target used, new one next cycle
        jump_en = 1; TargetIdx = 3; lut_we = 1; lut_addr = 3; lut_data = 'h111;
        cycle("rw_old");
        chk("rw_old_pc", 32'(ProgCtr), 'h200);
        lut_we = 0;
        cycle("rw_new");
        chk("rw_new_pc", 32'(ProgCtr), 'h111);
        quiet();

        for (int i = 0; i < 400; i++) begin
            Start     = ($urandom % 8) == 0;
            StartAddr = PW'($urandom);
            Halt      = ($urandom % 16) == 0;
            Stall     = ($urandom % 4) == 0;
            jump_en   = ($urandom % 4) == 0;
            branch_en = ($urandom % 3) == 0;
            TargetIdx = AW'($urandom);
            lut_we    = ($urandom % 3) == 0;
            lut_addr  = AW'($urandom);
            lut_data  = PW'($urandom);
            cycle("rand");
        end
        quiet();

        Start = 1; StartAddr = 'h000;
        cycle("rs");
        Start = 0; lut_write(7, 'h155);
        jump_en = 1; TargetIdx = 7;
        cycle("to155");
        chk("at155", 32'(ProgCtr), 'h155);
        jump_en = 0;
        #2 Reset = 0;
        #1;
        model_reset();
        check_model("async_rst");
        chk("async_rst_pc", 32'(ProgCtr), 0);
        Start = 1; StartAddr = 'h077;
        cycle("rst_start");
        chk("rst_start_run", 32'(Running), 0);
        #3 Reset = 1;
        StartAddr = 'h100;
        cycle("post_rst_start");
        Start = 0; jump_en = 1; TargetIdx = 7;
        cycle("lut_cleared");
        chk("lut_cleared_pc", 32'(ProgCtr), 0);
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
